stream_encryptor: RTL and testbench
===================================

STREAM_ENCRYPTOR -- requirements
Module: stream_encryptor

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL be the number of WAIT cycles without hash_byte_pulse before a timeout (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 nrst  input  1  reset, asynchronous, active-low.
REQ-004 plain_byte  input  8  plaintext byte from upstream.
REQ-005 plain_valid  input  1  plaintext byte available.
REQ-006 plain_ready  output  1  block accepts plaintext this cycle.
REQ-007 request_hash_byte_pulse  output  1  one-cycle request to hash generator for next keystream byte.
REQ-008 hash_byte  input  8  keystream byte, sampled only when hash_byte_pulse=1.
REQ-009 hash_byte_pulse  input  1  one-cycle strobe qualifying hash_byte.
REQ-010 cipher_byte  output  8  encrypted byte (registered).
REQ-011 cipher_valid  output  1  cipher_byte valid.
REQ-012 cipher_ready  input  1  downstream accepts cipher_byte.
REQ-013 byte_count  output  16  number of cipher bytes delivered since reset.
REQ-014 timeout_err  output  1  sticky flag: a hash request timed out.
REQ-015 clear_err  input  1  synchronous clear of timeout_err.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, OUT; all outputs Moore or registered.
REQ-017 IDLE: plain_ready=1; on plain_valid=1 capture plain_byte into internal register, go to REQ; else stay.
REQ-018 REQ: request_hash_byte_pulse=1 for exactly this one cycle, clear timeout counter, go to WAIT; hash_byte_pulse in REQ ignored.
REQ-019 WAIT: on hash_byte_pulse=1, load cipher_byte = captured plain byte XOR hash_byte, go to OUT.
REQ-020 WAIT: with no pulse, timeout counter increments each cycle; when count reaches TIMEOUT_CYCLES, set timeout_err=1 and return to REQ (re-request); captured plain byte retained.
REQ-021 OUT: cipher_valid=1, cipher_byte held stable; on cipher_ready=1 increment byte_count, go to IDLE.
REQ-022 plain_ready SHALL be 0 in REQ, WAIT, OUT; one byte in flight at most.
REQ-023 hash_byte_pulse outside WAIT SHALL be ignored with no state or data effect.
REQ-024 Latency: plain accepted cycle 0, request pulse cycle 1, earliest hash pulse cycle 2, cipher_valid cycle 3.
REQ-025 byte_count SHALL wrap 0xFFFF -> 0x0000 without flag.
REQ-026 timeout_err: clear_err=1 clears it; if timeout and clear_err coincide, timeout_err SHALL be 1 (set wins).
REQ-027 Throughput with zero-wait hash and cipher_ready=1: one byte per 4 cycles.

Reset
REQ-028 nrst=0 SHALL immediately force state IDLE, cipher_byte=0x00, cipher_valid=0, request_hash_byte_pulse=0, byte_count=0, timeout_err=0, timeout counter=0, captured byte=0x00.
REQ-029 Reset mid-operation (REQ/WAIT/OUT) SHALL drop the in-flight byte; first cycle after release is IDLE with plain_ready=1.

Verification
REQ-030 plain_byte=0x41 valid; hash_byte=0x5A pulsed cycle after request; cipher_ready=1 -> cipher_byte=0x1B, cipher_valid cycle 3, byte_count=1.
REQ-031 No hash pulse for 16 WAIT cycles -> timeout_err=1, second request pulse; then hash 0xFF -> cipher = plain XOR 0xFF; clear_err -> timeout_err=0.
REQ-032 cipher_ready=0 for 5 cycles in OUT -> cipher_valid and cipher_byte stable, plain_ready=0, byte_count unchanged until ready.
REQ-033 Stray hash_byte_pulse in IDLE and in REQ -> no cipher_valid, no state change.
REQ-034 byte_count preset by 65535 transfers, one more -> byte_count=0x0000.
REQ-035 nrst asserted during WAIT -> all outputs reset values asynchronously; late hash pulse after release ignored.

Source files
------------

// File: rtl/stream_encryptor.sv
// stream_encryptor: XORs each plaintext byte with one requested keystream byte, one byte in flight.
// Ports:
//   clk, nrst                  clock, asynchronous active-low reset
//   plain_byte/valid/ready     plaintext input handshake (ready only in IDLE)
//   request_hash_byte_pulse    one-cycle keystream request to the hash generator
//   hash_byte/hash_byte_pulse  keystream byte and its one-cycle strobe (honoured only in WAIT)
//   cipher_byte/valid/ready    registered ciphertext output handshake
//   byte_count                 cipher bytes delivered since reset, wraps at 16 bits
//   timeout_err/clear_err      sticky hash-timeout flag and its synchronous clear
module stream_encryptor #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  plain_byte,
  input  logic        plain_valid,
  output logic        plain_ready,
  output logic        request_hash_byte_pulse,
  input  logic [7:0]  hash_byte,
  input  logic        hash_byte_pulse,
  output logic [7:0]  cipher_byte,
  output logic        cipher_valid,
  input  logic        cipher_ready,
  output logic [15:0] byte_count,
  output logic        timeout_err,
  input  logic        clear_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;
  state_t state;
  logic [7:0] plain_q;
  logic [7:0] tcnt;
  logic timeout;
  // fires on the WAIT cycle that would bring the counter up to TIMEOUT_CYCLES
  assign timeout = state == WAIT && !hash_byte_pulse && tcnt == 8'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      plain_ready <= 1'b1;
      request_hash_byte_pulse <= 1'b0;
      cipher_byte <= 8'h00;
      cipher_valid <= 1'b0;
      plain_q <= 8'h00;
      tcnt <= 8'h00;
      byte_count <= 16'h0000;
      timeout_err <= 1'b0;
    end else begin
      // a timeout in the same cycle as clear_err leaves the flag set
      timeout_err <= timeout | (timeout_err & ~clear_err);
      case (state)
        IDLE: if (plain_valid) begin
          plain_q <= plain_byte;
          plain_ready <= 1'b0;
          request_hash_byte_pulse <= 1'b1;
          state <= REQ;
        end
        REQ: begin
          request_hash_byte_pulse <= 1'b0;
          tcnt <= 8'h00;
          state <= WAIT;
        end
        WAIT: if (hash_byte_pulse) begin
          cipher_byte <= plain_q ^ hash_byte;
          cipher_valid <= 1'b1;
          state <= OUT;
        end else if (timeout) begin
          request_hash_byte_pulse <= 1'b1;
          state <= REQ;
        end else tcnt <= tcnt + 8'd1;
        OUT: if (cipher_ready) begin
          cipher_valid <= 1'b0;
          plain_ready <= 1'b1;
          byte_count <= byte_count + 16'd1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stream_encryptor.sv
// tb_stream_encryptor: directed scenarios with hand-computed expectations for stream_encryptor.
module tb_stream_encryptor;
  logic clk = 1'b0, nrst = 1'b0;
  logic [7:0] plain_byte = 8'h00, hash_byte = 8'h00;
  logic plain_valid = 1'b0, hash_byte_pulse = 1'b0, cipher_ready = 1'b0, clear_err = 1'b0;
  logic plain_ready, request_hash_byte_pulse, cipher_valid, timeout_err;
  logic [7:0] cipher_byte;
  logic [15:0] byte_count;
  logic [15:0] exp_cnt = 16'h0000;
  int vecs = 0, errs = 0;
  logic [7:0] b2b_p [3] = '{8'hA5, 8'h00, 8'hFF};
  logic [7:0] b2b_h [3] = '{8'h5A, 8'hC3, 8'h0F};
  logic [7:0] b2b_c [3] = '{8'hFF, 8'hC3, 8'hF0};
  logic [2:0] fl;
  assign fl = {plain_ready, request_hash_byte_pulse, cipher_valid};

  always #5 clk = ~clk;

  stream_encryptor #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .nrst(nrst),
    .plain_byte(plain_byte), .plain_valid(plain_valid), .plain_ready(plain_ready),
    .request_hash_byte_pulse(request_hash_byte_pulse),
    .hash_byte(hash_byte), .hash_byte_pulse(hash_byte_pulse),
    .cipher_byte(cipher_byte), .cipher_valid(cipher_valid), .cipher_ready(cipher_ready),
    .byte_count(byte_count), .timeout_err(timeout_err), .clear_err(clear_err)
  );

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vecs++; if ({fl, timeout_err} !== 4'b1000) begin errs++; $display("FAIL reset_flags got %b want 1000", {fl, timeout_err}); end
    vecs++; if (cipher_byte !== 8'h00) begin errs++; $display("FAIL reset_cipher got %h want 00", cipher_byte); end
    vecs++; if (byte_count !== 16'h0000) begin errs++; $display("FAIL reset_count got %h want 0000", byte_count); end
    nrst = 1'b1;
    @(negedge clk);
    vecs++; if (fl !== 3'b100) begin errs++; $display("FAIL post_reset_idle got %b want 100", fl); end
  endtask

  task automatic test_basic();
    cipher_ready = 1'b1; plain_byte = 8'h41; plain_valid = 1'b1;
    @(negedge clk); plain_valid = 1'b0;
    vecs++; if (fl !== 3'b010) begin errs++; $display("FAIL basic_req got %b want 010", fl); end
    @(negedge clk); hash_byte = 8'h5A; hash_byte_pulse = 1'b1;
    vecs++; if (fl !== 3'b000) begin errs++; $display("FAIL basic_wait got %b want 000", fl); end
    @(negedge clk); hash_byte_pulse = 1'b0;
    vecs++; if (fl !== 3'b001) begin errs++; $display("FAIL basic_out got %b want 001", fl); end
    vecs++; if (cipher_byte !== 8'h1B) begin errs++; $display("FAIL basic_cipher got %h want 1b", cipher_byte); end
    exp_cnt++;
    @(negedge clk);
    vecs++; if (fl !== 3'b100) begin errs++; $display("FAIL basic_idle got %b want 100", fl); end
    vecs++; if (byte_count !== exp_cnt) begin errs++; $display("FAIL basic_count got %h want %h", byte_count, exp_cnt); end
  endtask

  task automatic test_timeout();
    plain_byte = 8'h3C; plain_valid = 1'b1;
    @(negedge clk); plain_valid = 1'b0;
    vecs++; if (fl !== 3'b010) begin errs++; $display("FAIL to_req1 got %b want 010", fl); end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 15) clear_err = 1'b1;
      vecs++; if ({fl, timeout_err} !== 4'b0000) begin errs++; $display("FAIL to_wait%0d got %b want 0000", i, {fl, timeout_err}); end
    end
    @(negedge clk); clear_err = 1'b0;
    vecs++; if ({fl, timeout_err} !== 4'b0101) begin errs++; $display("FAIL to_rereq_setwins got %b want 0101", {fl, timeout_err}); end
    @(negedge clk); hash_byte = 8'hFF; hash_byte_pulse = 1'b1;
    vecs++; if ({fl, timeout_err} !== 4'b0001) begin errs++; $display("FAIL to_wait2 got %b want 0001", {fl, timeout_err}); end
    @(negedge clk); hash_byte_pulse = 1'b0;
    vecs++; if ({fl, cipher_byte} !== {3'b001, 8'hC3}) begin errs++; $display("FAIL to_cipher got %b/%h want 001/c3", fl, cipher_byte); end
    exp_cnt++;
    @(negedge clk); clear_err = 1'b1;
    vecs++; if (byte_count !== exp_cnt) begin errs++; $display("FAIL to_count got %h want %h", byte_count, exp_cnt); end
    @(negedge clk); clear_err = 1'b0;
    vecs++; if (timeout_err !== 1'b0) begin errs++; $display("FAIL to_clear got %b want 0", timeout_err); end
  endtask

  task automatic test_backpressure();
    cipher_ready = 1'b0; plain_byte = 8'h77; plain_valid = 1'b1;
    @(negedge clk); plain_valid = 1'b0;
    @(negedge clk); hash_byte = 8'h0F; hash_byte_pulse = 1'b1;
    @(negedge clk); hash_byte_pulse = 1'b0; plain_byte = 8'hAA; plain_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vecs++; if ({fl, cipher_byte} !== {3'b001, 8'h78}) begin errs++; $display("FAIL bp_hold%0d got %b/%h want 001/78", i, fl, cipher_byte); end
      vecs++; if (byte_count !== exp_cnt) begin errs++; $display("FAIL bp_count%0d got %h want %h", i, byte_count, exp_cnt); end
      @(negedge clk);
    end
    plain_valid = 1'b0; cipher_ready = 1'b1;
    @(negedge clk); exp_cnt++;
    vecs++; if ({fl, byte_count} !== {3'b100, exp_cnt}) begin errs++; $display("FAIL bp_release got %b/%h want 100/%h", fl, byte_count, exp_cnt); end
  endtask

  task automatic test_stray();
    hash_byte = 8'h99; hash_byte_pulse = 1'b1;
    @(negedge clk); hash_byte_pulse = 1'b0;
    vecs++; if ({fl, cipher_byte} !== {3'b100, 8'h78}) begin errs++; $display("FAIL stray_idle got %b/%h want 100/78", fl, cipher_byte); end
    plain_byte = 8'h12; plain_valid = 1'b1;
    @(negedge clk); plain_valid = 1'b0; hash_byte_pulse = 1'b1;
    vecs++; if (fl !== 3'b010) begin errs++; $display("FAIL stray_req got %b want 010", fl); end
    @(negedge clk); hash_byte_pulse = 1'b0;
    vecs++; if (fl !== 3'b000) begin errs++; $display("FAIL stray_wait1 got %b want 000", fl); end
    @(negedge clk); hash_byte = 8'h34; hash_byte_pulse = 1'b1;
    vecs++; if (fl !== 3'b000) begin errs++; $display("FAIL stray_wait2 got %b want 000", fl); end
    @(negedge clk); hash_byte_pulse = 1'b0;
    vecs++; if ({fl, cipher_byte} !== {3'b001, 8'h26}) begin errs++; $display("FAIL stray_cipher got %b/%h want 001/26", fl, cipher_byte); end
    exp_cnt++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      plain_byte = b2b_p[i]; plain_valid = 1'b1;
      vecs++; if (fl !== 3'b100) begin errs++; $display("FAIL b2b_idle%0d got %b want 100", i, fl); end
      @(negedge clk); plain_valid = 1'b0;
      @(negedge clk); hash_byte = b2b_h[i]; hash_byte_pulse = 1'b1;
      @(negedge clk); hash_byte_pulse = 1'b0;
      vecs++; if ({fl, cipher_byte} !== {3'b001, b2b_c[i]}) begin errs++; $display("FAIL b2b_cipher%0d got %b/%h want 001/%h", i, fl, cipher_byte, b2b_c[i]); end
      exp_cnt++;
      @(negedge clk);
      vecs++; if (byte_count !== exp_cnt) begin errs++; $display("FAIL b2b_count%0d got %h want %h", i, byte_count, exp_cnt); end
    end
  endtask

  task automatic test_async_reset();
    plain_byte = 8'h55; plain_valid = 1'b1;
    @(negedge clk); plain_valid = 1'b0;
    @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    exp_cnt = 16'h0000;
    vecs++; if ({fl, timeout_err} !== 4'b1000) begin errs++; $display("FAIL ar_flags got %b want 1000", {fl, timeout_err}); end
    vecs++; if ({cipher_byte, byte_count} !== {8'h00, exp_cnt}) begin errs++; $display("FAIL ar_data got %h/%h want 00/0000", cipher_byte, byte_count); end
    @(negedge clk); nrst = 1'b1; hash_byte = 8'hAB; hash_byte_pulse = 1'b1;
    @(negedge clk); hash_byte_pulse = 1'b0;
    vecs++; if ({fl, cipher_byte} !== {3'b100, 8'h00}) begin errs++; $display("FAIL ar_late_pulse got %b/%h want 100/00", fl, cipher_byte); end
    @(negedge clk);
    vecs++; if ({fl, byte_count} !== {3'b100, exp_cnt}) begin errs++; $display("FAIL ar_idle got %b/%h want 100/0000", fl, byte_count); end
  endtask

  task automatic test_wrap();
    force dut.byte_count = 16'hFFFE;
    @(negedge clk);
    release dut.byte_count;
    exp_cnt = 16'hFFFE;
    for (int i = 0; i < 2; i++) begin
      plain_byte = 8'h01; plain_valid = 1'b1;
      @(negedge clk); plain_valid = 1'b0;
      @(negedge clk); hash_byte = 8'h02; hash_byte_pulse = 1'b1;
      @(negedge clk); hash_byte_pulse = 1'b0;
      exp_cnt++;
      @(negedge clk);
      vecs++; if (byte_count !== exp_cnt) begin errs++; $display("FAIL wrap_count%0d got %h want %h", i, byte_count, exp_cnt); end
    end
    vecs++; if ({timeout_err, byte_count} !== 17'h0_0000) begin errs++; $display("FAIL wrap_zero got %b/%h want 0/0000", timeout_err, byte_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_backpressure();
    test_stray();
    test_back_to_back();
    test_async_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
